cache_lookup_ctrl: RTL and testbench

Lookup and refill controller for the 4-way set-associative cache. Accepts one read request at a time and compares the request tag against the per-way valid bits and tags of the indexed set. On a miss it selects a victim way, fetches the line from memory over a req/ack handshake, and then drives the one-hot `valid_write` and `miss` strobes that feed the per-way valid-bit storage and the tag arrays.

---
 rtl/cache_lookup_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_cache_lookup_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// cache_lookup_ctrl
//
// Lookup and refill controller for a WAYS-way set-associative cache. One read
// request is handled at a time: the indexed set's valid bits and tags are
// compared against the request tag; on a miss a victim way is chosen, the line
// is fetched over a mem_req/mem_ack handshake, and one-hot write strobes are
// issued to the external valid-bit and tag arrays before responding.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (accepted only in IDLE)
//   req_index, req_tag    set index and tag of the request
//   set_index             registered index feeding the array read decoders
//   way_valid, way_tags   contents of the set at set_index (way k tag at
//                         bits [k*TAG_W +: TAG_W])
//   mem_req, mem_addr     line fetch request, address {tag, index}
//   mem_ack               fetch complete (honoured only while fetching)
//   valid_write,tag_write one-hot write enables for the victim way
//   tag_wdata             tag written on refill
//   miss                  refill strobe to the valid-bit storage
//   resp_valid/hit/way    one-cycle response
//
// Every output is either a flop or a decode of flops; no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module cache_lookup_ctrl #(
    parameter int WAYS    = 4,
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [INDEX_W-1:0]            req_index,
    input  logic [TAG_W-1:0]              req_tag,
    output logic [INDEX_W-1:0]            set_index,
    input  logic [WAYS-1:0]               way_valid,
    input  logic [WAYS*TAG_W-1:0]         way_tags,
    output logic                          mem_req,
    output logic [INDEX_W+TAG_W-1:0]      mem_addr,
    input  logic                          mem_ack,
    output logic [WAYS-1:0]               valid_write,
    output logic [WAYS-1:0]               tag_write,
    output logic [TAG_W-1:0]              tag_wdata,
    output logic                          miss,
    output logic                          resp_valid,
    output logic                          resp_hit,
    output logic [$clog2(WAYS)-1:0]       resp_way
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FETCH,
        ST_UPDATE,
        ST_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [WAY_W-1:0]     way_q, way_d;        // hit way or victim way
    logic                 hit_q, hit_d;
    logic                 from_rr_q, from_rr_d; // victim came from the pointer

    // Per-set round-robin replacement pointers.
    logic [WAY_W-1:0]     rr_q [SETS];
    logic [WAY_W-1:0]     rr_d [SETS];

    // Tag compare per way.
    logic [WAYS-1:0]      hit_vec;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_cmp
            assign hit_vec[gi] = way_valid[gi] &&
                                 (way_tags[gi*TAG_W +: TAG_W] == tag_q);
        end
    endgenerate

    // Lowest-index hit and lowest-index invalid way. Scanning downward lets
    // the last assignment win, which is the lowest index. On multiple tag
    // matches this simply picks the lowest matching way.
    logic                 hit_any;
    logic [WAY_W-1:0]     hit_way;
    logic                 inv_any;
    logic [WAY_W-1:0]     inv_way;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(k);
            end
            if (!way_valid[k]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(k);
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        tag_d       = tag_q;
        way_d       = way_q;
        hit_d       = hit_q;
        from_rr_d   = from_rr_q;

        req_ready   = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        valid_write = '0;
        tag_write   = '0;
        tag_wdata   = '0;
        miss        = 1'b0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        resp_way    = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    index_d = req_index;
                    tag_d   = req_tag;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit_any) begin
                    way_d   = hit_way;
                    hit_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    hit_d = 1'b0;
                    if (inv_any) begin
                        way_d     = inv_way;
                        from_rr_d = 1'b0;
                    end else begin
                        way_d     = rr_q[index_q];
                        from_rr_d = 1'b1;
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, index_q};
                if (mem_ack) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                valid_write = WAYS'(1) << way_q;
                tag_write   = WAYS'(1) << way_q;
                tag_wdata   = tag_q;
                miss        = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                resp_way   = way_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The pointer advances only once the refill it chose actually lands, so
    // a fetch abandoned by reset leaves it untouched (reset clears it anyway).
    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            rr_d[s] = rr_q[s];
            if ((state_q == ST_UPDATE) && from_rr_q && (index_q == INDEX_W'(s))) begin
                rr_d[s] = rr_q[s] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            tag_q     <= '0;
            way_q     <= '0;
            hit_q     <= 1'b0;
            from_rr_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            tag_q     <= tag_d;
            way_q     <= way_d;
            hit_q     <= hit_d;
            from_rr_q <= from_rr_d;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= rr_d[s];
            end
        end
    end

    assign set_index = index_q;

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_lookup_ctrl
//
// Bench for cache_lookup_ctrl. The bench owns the valid/tag storage (read
// through the DUT's set_index, written by its strobes) and a transaction
// model: for each request it works out hit/victim from the stored set and a
// per-set replacement pointer, then lays out the expected output timeline
// cycle by cycle. A negedge process compares every output every cycle.
// ---------------------------------------------------------------------------
module tb_cache_lookup_ctrl;

    localparam int WAYS    = 4;
    localparam int INDEX_W = 3;
    localparam int TAG_W   = 8;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     req_valid = 1'b0;
    logic                     req_ready;
    logic [INDEX_W-1:0]       req_index = '0;
    logic [TAG_W-1:0]         req_tag = '0;
    logic [INDEX_W-1:0]       set_index;
    logic [WAYS-1:0]          way_valid;
    logic [WAYS*TAG_W-1:0]    way_tags;
    logic                     mem_req;
    logic [INDEX_W+TAG_W-1:0] mem_addr;
    logic                     mem_ack = 1'b0;
    logic [WAYS-1:0]          valid_write;
    logic [WAYS-1:0]          tag_write;
    logic [TAG_W-1:0]         tag_wdata;
    logic                     miss;
    logic                     resp_valid;
    logic                     resp_hit;
    logic [1:0]               resp_way;

    always #5 clk = ~clk;

    cache_lookup_ctrl #(
        .WAYS    (WAYS),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_index   (req_index),
        .req_tag     (req_tag),
        .set_index   (set_index),
        .way_valid   (way_valid),
        .way_tags    (way_tags),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .valid_write (valid_write),
        .tag_write   (tag_write),
        .tag_wdata   (tag_wdata),
        .miss        (miss),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_way    (resp_way)
    );

    // Cache storage as seen by the controller.
    bit         arr_v [8][4];
    logic [7:0] arr_t [8][4];

    always_comb begin
        way_valid = '0;
        way_tags  = '0;
        for (int w = 0; w < 4; w++) begin
            way_valid[w]         = arr_v[set_index][w];
            way_tags[w*8 +: 8]   = arr_t[set_index][w];
        end
    end

    // Model state and per-cycle expectations.
    int          rr_m [8];
    int          cur_set;
    int          cyc;
    bit          chk_en;
    int          n_vec;
    int          n_err;
    bit          m_hit;
    int          m_way;
    logic [10:0] m_addr;

    logic        e_ready, e_mreq, e_miss, e_rv, e_rh;
    logic [2:0]  e_set;
    logic [10:0] e_maddr;
    logic [3:0]  e_vw, e_tw;
    logic [7:0]  e_twd;
    logic [1:0]  e_rw;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            cmp("req_ready",   32'(req_ready),   32'(e_ready));
            cmp("set_index",   32'(set_index),   32'(e_set));
            cmp("mem_req",     32'(mem_req),     32'(e_mreq));
            cmp("mem_addr",    32'(mem_addr),    32'(e_maddr));
            cmp("valid_write", 32'(valid_write), 32'(e_vw));
            cmp("tag_write",   32'(tag_write),   32'(e_tw));
            cmp("tag_wdata",   32'(tag_wdata),   32'(e_twd));
            cmp("miss",        32'(miss),        32'(e_miss));
            cmp("resp_valid",  32'(resp_valid),  32'(e_rv));
            cmp("resp_hit",    32'(resp_hit),    32'(e_rh));
            cmp("resp_way",    32'(resp_way),    32'(e_rw));
        end
    end

    // Literal checks on the model's own predictions.
    task automatic pin(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL pin_%s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        e_ready = 1'b1; e_set = 3'(cur_set); e_mreq = 1'b0; e_maddr = '0;
        e_vw = '0; e_tw = '0; e_twd = '0; e_miss = 1'b0;
        e_rv = 1'b0; e_rh = 1'b0; e_rw = '0;
    endtask

    // End the current cycle: storage captures any write strobe at the edge.
    task automatic step();
        for (int w = 0; w < 4; w++) begin
            if (valid_write[w]) begin
                arr_v[set_index][w] = 1'b1;
                arr_t[set_index][w] = tag_wdata;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            set_idle();
            step();
        end
        mem_ack = 1'b0;
    endtask

    // One request starting in the current (idle) cycle.
    task automatic do_req(input logic [2:0] idx, input logic [7:0] tag, input int ack_dly,
                          input bit noise, input bit hold, input logic [2:0] nidx,
                          input logic [7:0] ntag, input bit rst_fetch);
        int  hw;
        int  vic;
        bit  from_rr;
        hw  = -1;
        vic = -1;
        for (int w = 0; w < 4; w++) begin
            if (hw < 0 && arr_v[idx][w] && arr_t[idx][w] == tag) hw = w;
            if (vic < 0 && !arr_v[idx][w]) vic = w;
        end
        from_rr = (vic < 0);
        if (from_rr) vic = rr_m[idx];
        m_hit  = (hw >= 0);
        m_way  = m_hit ? hw : vic;
        m_addr = {tag, idx};

        // Cycle N: request presented while idle.
        req_valid = 1'b1; req_index = idx; req_tag = tag; mem_ack = noise;
        set_idle();
        step();
        // N+1: lookup.
        cur_set = idx;
        if (hold) begin
            req_index = nidx; req_tag = ntag;
        end else begin
            req_valid = 1'b0;
        end
        mem_ack = noise;
        set_idle(); e_ready = 1'b0;
        step();
        mem_ack = 1'b0;
        if (m_hit) begin
            set_idle(); e_ready = 1'b0; e_rv = 1'b1; e_rh = 1'b1; e_rw = 2'(hw);
            step();
            set_idle();
            return;
        end
        for (int d = 0; d <= ack_dly; d++) begin
            set_idle(); e_ready = 1'b0; e_mreq = 1'b1; e_maddr = m_addr;
            if (rst_fetch && d == 2) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                cur_set = 0;
                for (int s = 0; s < 8; s++) rr_m[s] = 0;
                mem_ack = 1'b1;          // late ack, must be ignored
                set_idle();
                step();
                mem_ack = 1'b0;
                set_idle();
                step();
                set_idle();
                return;
            end
            mem_ack = (d == ack_dly);
            step();
        end
        // Refill strobes.
        mem_ack = 1'b0;
        set_idle(); e_ready = 1'b0;
        e_vw = 4'(1 << vic); e_tw = 4'(1 << vic); e_twd = tag; e_miss = 1'b1;
        if (from_rr) rr_m[idx] = (rr_m[idx] + 1) % 4;
        step();
        set_idle(); e_ready = 1'b0; e_rv = 1'b1; e_rh = 1'b0; e_rw = 2'(vic);
        step();
        set_idle();
    endtask

    initial begin
        int seq [5];
        cyc = 0; n_vec = 0; n_err = 0; chk_en = 1'b0; cur_set = 0;
        for (int s = 0; s < 8; s++) begin
            rr_m[s] = 0;
            for (int w = 0; w < 4; w++) begin
                arr_v[s][w] = 1'b0;
                arr_t[s][w] = 8'($urandom_range(0, 255));
            end
        end
        set_idle();
        step();
        set_idle();
        chk_en = 1'b1;         // reset still high: outputs must hold reset values
        step();
        reset = 1'b0;
        idle(2, 1'b0);

        // Hit in set 2 way 1.
        arr_v[2][1] = 1'b1; arr_t[2][1] = 8'h5A;
        do_req(3'd2, 8'h5A, 0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        pin("hit1", int'(m_hit), 1);
        pin("hitway1", m_way, 1);
        idle(2, 1'b0);

        // Miss into invalid way 2 of set 3, ack after 5 cycles.
        arr_v[3][0] = 1'b1; arr_t[3][0] = 8'h20;
        arr_v[3][1] = 1'b1; arr_t[3][1] = 8'h21;
        arr_v[3][2] = 1'b0;
        arr_v[3][3] = 1'b1; arr_t[3][3] = 8'h23;
        do_req(3'd3, 8'h11, 5, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        pin("victim2", m_way, 2);
        pin("addr2", int'(m_addr), 'h08B);
        pin("rr3", rr_m[3], 0);
        idle(2, 1'b0);

        // Five misses to full set 5: round robin 0,1,2,3 then wrap.
        for (int w = 0; w < 4; w++) begin
            arr_v[5][w] = 1'b1; arr_t[5][w] = 8'(w + 1);
        end
        for (int i = 0; i < 5; i++) begin
            do_req(3'd5, 8'(8'hA0 + i), i % 3, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
            seq[i] = m_way;
            idle(1, 1'b0);
        end
        pin("rr_seq0", seq[0], 0);
        pin("rr_seq1", seq[1], 1);
        pin("rr_seq2", seq[2], 2);
        pin("rr_seq3", seq[3], 3);
        pin("rr_seq4", seq[4], 0);

        // Ack pulsed in idle and lookup, then held on entry to fetch.
        for (int w = 0; w < 4; w++) arr_v[4][w] = 1'b0;
        do_req(3'd4, 8'h77, 0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(2, 1'b0);

        // Reset two cycles into a fetch.
        do_req(3'd5, 8'hC3, 6, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(2, 1'b0);
        // Pointer of set 5 was cleared by reset: next full-set miss uses way 0.
        do_req(3'd5, 8'hC4, 1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        pin("rr_after_reset", m_way, 0);
        idle(1, 1'b0);

        // Back-to-back: req_valid held through a hit, second request to set 6.
        arr_v[7][2] = 1'b1; arr_t[7][2] = 8'h42;
        arr_v[6][0] = 1'b1; arr_t[6][0] = 8'h31;
        do_req(3'd7, 8'h42, 0, 1'b0, 1'b1, 3'd6, 8'h31, 1'b0);
        do_req(3'd6, 8'h31, 0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        pin("b2b_way", m_way, 0);
        idle(1, 1'b0);

        // Duplicate tags in set 0: lowest matching way, no refill.
        for (int w = 0; w < 4; w++) arr_v[0][w] = 1'b0;
        arr_v[0][1] = 1'b1; arr_t[0][1] = 8'h33;
        arr_v[0][3] = 1'b1; arr_t[0][3] = 8'h33;
        do_req(3'd0, 8'h33, 0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        pin("dup_way", m_way, 1);
        idle(1, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                arr_v[$urandom_range(0, 7)][$urandom_range(0, 3)] = 1'b0;
            end
            do_req(3'($urandom_range(0, 7)), 8'(8'h40 + $urandom_range(0, 5)),
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                   1'b0, 3'd0, 8'h00, 1'b0);
            idle($urandom_range(0, 2), 1'b1);
        end

        idle(2, 1'b0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
